uart_receiver: RTL and testbench
================================

// Module: uart_receiver
// PURPOSE
//  Serial-to-parallel UART receive path; counterpart of the team's UART transmitter.
//  - Frame: 1 start bit (low), NBITS data bits MSB first, STPBITS stop bits (high); idle line high.
//  - Oversamples rx at OVERSAMPLE ticks per bit; samples every bit at its midpoint.
//  - Delivers each byte with a one-cycle rx_done strobe and a framing-error flag to the host logic.
// PARAMETERS
//  NBITS          8   data bits per frame (1..16)
//  STPBITS        2   stop bits checked per frame (1..2)
//  OVERSAMPLE     16  ticks per bit period (even, >=4)
//  CLKS_PER_TICK  10  clk cycles per oversample tick (>=2)
// PORTS
//  clk        in   1      system clock, all logic on rising edge
//  reset      in   1      asynchronous, active-low reset
//  rx         in   1      serial input, asynchronous to clk
//  rx_dout    out  NBITS  last received data word, MSB = first data bit on the line
//  rx_done    out  1      one-clk pulse: rx_dout/frame_err updated this cycle
//  frame_err  out  1      1 = a stop bit sampled low in the last frame; valid from rx_done until the next rx_done
//  busy       out  1      1 while a frame is being received (state != IDLE)
// BEHAVIOUR
//  - Reset (reset=0, any time, including mid-frame):
//    - outputs: rx_dout=0, rx_done=0, frame_err=0, busy=0.
//    - internal: state=IDLE, all counters=0, synchroniser flops=1.
//  - rx passes through a 2-flop synchroniser (rx_s); all decisions use rx_s only.
//  - Tick divider: counter 0..CLKS_PER_TICK-1; tick=1 for one clk when counter==CLKS_PER_TICK-1.
//    Counter is forced to 0 on the cycle a start edge is detected, so sample phase is deterministic.
//  - FSM states:
//    - IDLE: rx_s==0 -> START, clear tick divider and tick_cnt. Otherwise stay.
//    - START: on the tick where tick_cnt reaches OVERSAMPLE/2, sample rx_s.
//      - rx_s==1: false start, back to IDLE; no rx_done, no output change.
//      - rx_s==0: go to DATA; tick_cnt=0, bit_cnt=0.
//    - DATA: every OVERSAMPLE ticks, shreg <= {shreg[NBITS-2:0], rx_s} and bit_cnt++.
//      After NBITS samples -> STOP, bit_cnt=0.
//    - STOP: every OVERSAMPLE ticks, sample one stop bit; any low sample sets err_acc.
//      After STPBITS samples, on the next clk:
//      - rx_dout<=shreg; frame_err<=err_acc; rx_done=1 for exactly one clk; state -> IDLE.
//  - rx_dout is updated even when frame_err=1. No stop-bit wait: a new start can be detected from the cycle after rx_done.
//  - Latency: rx_done asserts (2 sync + 1) clks + (OVERSAMPLE/2 + OVERSAMPLE*(NBITS+STPBITS))*CLKS_PER_TICK clks after the rx falling edge.
//    With defaults: 3 + 168*10 = 1683 clks.
//  - rx changes mid-frame affect only the sample taken at each midpoint.
//  - A low line held through IDLE->START->DATA is received as data 0x00 with frame_err=1 if the stop bits stay low.
//  - Counter widths: sized with $clog2 of the parameters; tick_cnt and bit_cnt never wrap inside a frame.
// TESTING  (defaults: 1 bit = 160 clk)
//  1. Send 0xA5, 2 stop bits high -> one rx_done pulse, rx_dout=0xA5, frame_err=0, busy low after pulse.
//  2. Drive rx low for 40 clk, then high -> no rx_done, busy returns 0, rx_dout unchanged.
//  3. Send 0x3C with 2nd stop bit low -> rx_done, rx_dout=0x3C, frame_err=1.
//     Next frame 0x11 clean -> frame_err=0.
//  4. Back-to-back 0x00 then 0xFF, no idle gap beyond stop bits -> two rx_done pulses in order, values 0x00 and 0xFF.
//  5. Assert reset after 4 data bits of 0x5A -> all outputs 0 at once, no rx_done.
//     Release reset and send 0x5A -> rx_dout=0x5A.
//  6. Measure edge-to-rx_done for 0x81 -> exactly 1683 clk; rx_done width exactly 1 clk.

Source files
------------

// File: rtl/uart_receiver.sv
// UART receive path: 2-flop synchronised rx, oversampled mid-bit sampling,
// MSB-first data shift register, stop-bit framing check and a one-clock
// rx_done strobe that publishes rx_dout/frame_err to the host logic.
module uart_receiver #(
    parameter int NBITS         = 8,
    parameter int STPBITS       = 2,
    parameter int OVERSAMPLE    = 16,
    parameter int CLKS_PER_TICK = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx,
    output logic [NBITS-1:0] rx_dout,
    output logic             rx_done,
    output logic             frame_err,
    output logic             busy
);

    localparam int DIVW  = $clog2(CLKS_PER_TICK);
    localparam int TICKW = $clog2(OVERSAMPLE);
    localparam int BITW  = $clog2(((NBITS > STPBITS) ? NBITS : STPBITS) + 1);

    localparam logic [DIVW-1:0]  DIV_LAST      = DIVW'(CLKS_PER_TICK - 1);
    localparam logic [TICKW-1:0] TICK_MID_LAST = TICKW'(OVERSAMPLE / 2 - 1);
    localparam logic [TICKW-1:0] TICK_LAST     = TICKW'(OVERSAMPLE - 1);
    localparam logic [BITW-1:0]  DATA_LAST     = BITW'(NBITS - 1);
    localparam logic [BITW-1:0]  STOP_LAST     = BITW'(STPBITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t             state_q;
    logic               rxMeta_q;
    logic               rxSync_q;
    logic [DIVW-1:0]    divCnt_q;
    logic [DIVW-1:0]    divCnt_d;
    logic [TICKW-1:0]   tickCnt_q;
    logic [BITW-1:0]    bitCnt_q;
    logic [NBITS-1:0]   shReg_q;
    logic               errAcc_q;
    logic [NBITS-1:0]   rxDout_q;
    logic               rxDone_q;
    logic               frameErr_q;
    logic               tick;
    logic               startEdge;

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rxMeta_q <= 1'b1;
            rxSync_q <= 1'b1;
        end else begin
            rxMeta_q <= rx;
            rxSync_q <= rxMeta_q;
        end
    end

    assign startEdge = (state_q == IDLE) && !rxSync_q;
    assign tick      = (divCnt_q == DIV_LAST);

    // Tick divider next state; a start edge realigns the sample phase.
    always_comb begin
        divCnt_d = divCnt_q + DIVW'(1);
        if (startEdge || tick) begin
            divCnt_d = '0;
        end
    end

    // Tick divider register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            divCnt_q <= '0;
        end else begin
            divCnt_q <= divCnt_d;
        end
    end

    // Receive FSM with registered outputs; the last stop sample publishes the word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            tickCnt_q  <= '0;
            bitCnt_q   <= '0;
            shReg_q    <= '0;
            errAcc_q   <= 1'b0;
            rxDout_q   <= '0;
            rxDone_q   <= 1'b0;
            frameErr_q <= 1'b0;
        end else begin
            rxDone_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!rxSync_q) begin
                        state_q   <= START;
                        tickCnt_q <= '0;
                        bitCnt_q  <= '0;
                        errAcc_q  <= 1'b0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (tickCnt_q == TICK_MID_LAST) begin
                            tickCnt_q <= '0;
                            bitCnt_q  <= '0;
                            state_q   <= rxSync_q ? IDLE : DATA;
                        end else begin
                            tickCnt_q <= tickCnt_q + TICKW'(1);
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (tickCnt_q == TICK_LAST) begin
                            tickCnt_q <= '0;
                            shReg_q   <= (shReg_q << 1) | NBITS'(rxSync_q);
                            if (bitCnt_q == DATA_LAST) begin
                                bitCnt_q <= '0;
                                errAcc_q <= 1'b0;
                                state_q  <= STOP;
                            end else begin
                                bitCnt_q <= bitCnt_q + BITW'(1);
                            end
                        end else begin
                            tickCnt_q <= tickCnt_q + TICKW'(1);
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (tickCnt_q == TICK_LAST) begin
                            tickCnt_q <= '0;
                            if (bitCnt_q == STOP_LAST) begin
                                bitCnt_q   <= '0;
                                rxDout_q   <= shReg_q;
                                frameErr_q <= errAcc_q | !rxSync_q;
                                rxDone_q   <= 1'b1;
                                state_q    <= IDLE;
                            end else begin
                                bitCnt_q <= bitCnt_q + BITW'(1);
                                errAcc_q <= errAcc_q | !rxSync_q;
                            end
                        end else begin
                            tickCnt_q <= tickCnt_q + TICKW'(1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rx_dout   = rxDout_q;
    assign rx_done   = rxDone_q;
    assign frame_err = frameErr_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at default parameters (1 bit = 160 clk).
// Frames push their expected word onto a queue; a monitor pops on rx_done.
module tb_uart_receiver;

    localparam int BITCLKS = 160;

    typedef struct {
        logic [7:0] data;
        logic       err;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       rx;
    logic [7:0] rx_dout;
    logic       rx_done;
    logic       frame_err;
    logic       busy;

    exp_t expQ[$];
    int   vectors;
    int   miscompares;
    int   latency;
    logic seen;

    uart_receiver dut (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .rx_dout  (rx_dout),
        .rx_done  (rx_done),
        .frame_err(frame_err),
        .busy     (busy)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts the vector and reports a miscompare.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Hold rx at one level for one bit period.
    task automatic holdBit(input logic b);
        #1 rx = b;
        repeat (BITCLKS) @(posedge clk);
    endtask

    // Send one frame MSB first and record what the receiver should report.
    task automatic applyStimulus(input logic [7:0] data, input logic stop1,
                                 input logic stop2);
        exp_t e;
        e.data = data;
        e.err  = !(stop1 && stop2);
        expQ.push_back(e);
        @(posedge clk);
        holdBit(1'b0);
        for (int i = 7; i >= 0; i--) holdBit(data[i]);
        holdBit(stop1);
        holdBit(stop2);
        #1 rx = 1'b1;
    endtask

    // Wait (bounded) until every expected frame has been delivered.
    task automatic waitDrain();
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 4000) begin
            @(posedge clk);
            n++;
        end
        #2;
        checkOutput("drain_pending", expQ.size(), 0);
    endtask

    // Scoreboard monitor: every rx_done must match the oldest queued frame.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (reset === 1'b1 && rx_done === 1'b1) begin
            checkOutput("done_expected", {31'b0, expQ.size() != 0}, 1);
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                checkOutput("rx_dout", rx_dout, e.data);
                checkOutput("frame_err", frame_err, e.err);
            end
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rx          = 1'b1;
        reset       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_dout", rx_dout, 0);
        checkOutput("reset_done", rx_done, 0);
        checkOutput("reset_ferr", frame_err, 0);
        checkOutput("reset_busy", busy, 0);
        reset = 1'b1;
        repeat (20) @(posedge clk);

        $display("[TB] clean frame 0xA5");
        applyStimulus(8'hA5, 1'b1, 1'b1);
        waitDrain();
        checkOutput("busy_after_a5", busy, 0);

        $display("[TB] false start");
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (40) @(posedge clk);
        #1 rx = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checkOutput("busy_false_start_mid", busy, 1);
        repeat (300) @(posedge clk);
        #1;
        checkOutput("busy_false_start_end", busy, 0);
        checkOutput("dout_false_start", rx_dout, 8'hA5);

        $display("[TB] framing error then clean frame");
        applyStimulus(8'h3C, 1'b1, 1'b0);
        waitDrain();
        repeat (400) @(posedge clk);
        applyStimulus(8'h11, 1'b1, 1'b1);
        waitDrain();

        $display("[TB] back-to-back frames");
        applyStimulus(8'h00, 1'b1, 1'b1);
        applyStimulus(8'hFF, 1'b1, 1'b1);
        waitDrain();

        $display("[TB] reset mid-frame");
        @(posedge clk);
        holdBit(1'b0);
        holdBit(1'b0);
        holdBit(1'b1);
        holdBit(1'b0);
        holdBit(1'b1);
        #1;
        checkOutput("busy_before_reset", busy, 1);
        reset = 1'b0;
        #1;
        checkOutput("midreset_dout", rx_dout, 0);
        checkOutput("midreset_done", rx_done, 0);
        checkOutput("midreset_ferr", frame_err, 0);
        checkOutput("midreset_busy", busy, 0);
        rx = 1'b1;
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        repeat (20) @(posedge clk);
        applyStimulus(8'h5A, 1'b1, 1'b1);
        waitDrain();

        $display("[TB] latency of 0x81");
        latency = 0;
        seen    = 1'b0;
        fork
            applyStimulus(8'h81, 1'b1, 1'b1);
            begin
                @(posedge clk);
                #1;
                while (!seen && latency < 2000) begin
                    @(posedge clk);
                    latency++;
                    #1;
                    if (rx_done === 1'b1) seen = 1'b1;
                end
                checkOutput("latency", latency, 1683);
                @(posedge clk);
                #1;
                checkOutput("done_width", rx_done, 0);
            end
        join
        waitDrain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
